// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU controller.
//   - opcode encodings understood by the ALU and the controller
//   - controller state enum
//   - default datapath width and an opcode legality helper
package alu_pkg;

  localparam int W_DEF = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes 100/101/110 have no ALU function.
  function automatic logic op_legal(input logic [2:0] op);
    return !(op == 3'b100 || op == 3'b101 || op == 3'b110);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester arbiter, purely combinational.
//   req[1:0]  request vector
//   en        grants only when high
//   fair      1 = round-robin using ptr on contention, 0 = port 0 wins
//   ptr       current preferred port (0/1), held by the caller
//   gnt[1:0]  one-hot grant, or 0
//   ptr_nxt   next pointer value: toggles on every grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       fair,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (fair && ptr) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer flips after any grant, independent of which port won.
  assign ptr_nxt = (|gnt) ? ~ptr : ptr;

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters
// (port 0 = execute stage, port 1 = branch/address unit).
//   clk, rst_n               clock, async active-low reset
//   rqN_valid/ready/op/a/b   request handshake and operands, N = 0,1
//   rsN_valid/ready/result   response handshake and result
//   alu_a/alu_b/alu_ctrl     operands and control to the ALU
//   alu_result               ALU output (combinational)
//   busy                     high whenever not IDLE
//   op_err                   high during EXEC of an illegal opcode
// Optional build macro ALU_SHARE_FLAGS_EN adds alu_cout/alu_ovf inputs and
// rsN_flags = {cout, ovf, zero} outputs captured alongside the result.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter bit FAIR_RR = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rq0_valid,
  output logic         rq0_ready,
  input  logic [2:0]   rq0_op,
  input  logic [W-1:0] rq0_a,
  input  logic [W-1:0] rq0_b,
  output logic         rs0_valid,
  input  logic         rs0_ready,
  output logic [W-1:0] rs0_result,
  input  logic         rq1_valid,
  output logic         rq1_ready,
  input  logic [2:0]   rq1_op,
  input  logic [W-1:0] rq1_a,
  input  logic [W-1:0] rq1_b,
  output logic         rs1_valid,
  input  logic         rs1_ready,
  output logic [W-1:0] rs1_result,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
`ifdef ALU_SHARE_FLAGS_EN
  input  logic         alu_cout,
  input  logic         alu_ovf,
  output logic [2:0]   rs0_flags,
  output logic [2:0]   rs1_flags,
`endif
  output logic         busy,
  output logic         op_err
);

  state_t       state;
  logic         owner;   // port that owns the in-flight op
  logic         ptr;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q, result_q, res_pp;
  logic [1:0]   gnt;
  logic         ptr_nxt;
  logic [2:0]   sel_op;
  logic [W-1:0] sel_a, sel_b;

  rr_arb2 u_arb (
    .req     ({rq1_valid, rq0_valid}),
    .en      (state == IDLE),
    .fair    (FAIR_RR),
    .ptr     (ptr),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  assign rq0_ready = gnt[0];
  assign rq1_ready = gnt[1];

  assign sel_op = gnt[1] ? rq1_op : rq0_op;
  assign sel_a  = gnt[1] ? rq1_a  : rq0_a;
  assign sel_b  = gnt[1] ? rq1_b  : rq0_b;

  // Operand registers double as the ALU drive: they only change on accept,
  // so the ALU inputs hold their last value outside EXEC.
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;

  // SLT is resolved here from the latched operands; illegal ops yield 0.
  always_comb begin
    res_pp = '0;
    case (op_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB: res_pp = alu_result;
      OP_SLT: res_pp = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: res_pp = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      ptr      <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner  <= gnt[1];
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            ptr    <= ptr_nxt;
            op_err <= !op_legal(sel_op);
            state  <= EXEC;
          end
        end
        EXEC: begin
          result_q <= res_pp;
          op_err   <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          if (owner ? rs1_ready : rs0_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign rs0_valid  = (state == RESP) && !owner;
  assign rs1_valid  = (state == RESP) &&  owner;
  assign rs0_result = rs0_valid ? result_q : '0;
  assign rs1_result = rs1_valid ? result_q : '0;

`ifdef ALU_SHARE_FLAGS_EN
  logic [2:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              flags_q <= '0;
    else if (state == EXEC)  flags_q <= {alu_cout, alu_ovf, (res_pp == '0)};
  end

  assign rs0_flags = rs0_valid ? flags_q : '0;
  assign rs1_flags = rs1_valid ? flags_q : '0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU in the loop.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk, rst_n;
  logic         rq0_valid, rq0_ready, rs0_valid, rs0_ready;
  logic [2:0]   rq0_op;
  logic [W-1:0] rq0_a, rq0_b, rs0_result;
  logic         rq1_valid, rq1_ready, rs1_valid, rs1_ready;
  logic [2:0]   rq1_op;
  logic [W-1:0] rq1_a, rq1_b, rs1_result;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctrl;
  logic         busy, op_err;
  logic         alu_cout, alu_ovf;
  logic [2:0]   last_flags;
`ifdef ALU_SHARE_FLAGS_EN
  logic [2:0]   rs0_flags, rs1_flags;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_share_ctrl #(.W(W), .FAIR_RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op),
    .rq0_a(rq0_a), .rq0_b(rq0_b),
    .rs0_valid(rs0_valid), .rs0_ready(rs0_ready), .rs0_result(rs0_result),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op),
    .rq1_a(rq1_a), .rq1_b(rq1_b),
    .rs1_valid(rs1_valid), .rs1_ready(rs1_ready), .rs1_result(rs1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
`ifdef ALU_SHARE_FLAGS_EN
    .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .rs0_flags(rs0_flags), .rs1_flags(rs1_flags),
`endif
    .busy(busy), .op_err(op_err)
  );

  // Behavioural ALU; SLT and illegal codes return junk so the controller's
  // override is actually exercised.
  logic [W:0] sum17;
  always_comb begin
    sum17      = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = alu_a ^ alu_b ^ 16'h5A5A;
    alu_cout   = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_ctrl)
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_ADD: begin
        alu_result = sum17[W-1:0];
        alu_cout   = sum17[W];
        alu_ovf    = (alu_a[W-1] == alu_b[W-1]) && (sum17[W-1] != alu_a[W-1]);
      end
      OP_SUB: alu_result = alu_a - alu_b;
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction with the response consumed immediately.
  task automatic run_op(input logic port, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input logic err);
    @(negedge clk);
    if (port) begin rq1_valid = 1; rq1_op = op; rq1_a = a; rq1_b = b; end
    else      begin rq0_valid = 1; rq0_op = op; rq0_a = a; rq0_b = b; end
    #1;
    chk("rq_ready", {rq1_ready, rq0_ready}, port ? 2'b10 : 2'b01);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    rq0_valid = 0; rq1_valid = 0;
    chk("busy_exec", busy, 1);
    chk("op_err_exec", op_err, err);
    chk("alu_ctrl", alu_ctrl, op);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("rs_valid_exec", {rs1_valid, rs0_valid}, 0);
    @(posedge clk); #1;
    chk("rs_valid_resp", {rs1_valid, rs0_valid}, port ? 2'b10 : 2'b01);
    chk("rs_result", port ? rs1_result : rs0_result, exp);
    chk("rs_result_other", port ? rs0_result : rs1_result, 0);
    chk("op_err_resp", op_err, 0);
`ifdef ALU_SHARE_FLAGS_EN
    last_flags = port ? rs1_flags : rs0_flags;
`endif
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
    chk("rs_valid_after", {rs1_valid, rs0_valid}, 0);
  endtask

  typedef struct {
    logic         port;
    logic [2:0]   op;
    logic [W-1:0] a, b, exp;
    logic         err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, OP_ADD, 16'h0005, 16'h0003, 16'h0008, 1'b0};
    vecs[1] = '{1'b0, OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
    vecs[2] = '{1'b0, OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b0};
    vecs[3] = '{1'b0, OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0};
    vecs[4] = '{1'b1, OP_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0};
    vecs[5] = '{1'b1, OP_SLT, 16'h8000, 16'h0001, 16'h0001, 1'b0};
    vecs[6] = '{1'b1, OP_SLT, 16'h0001, 16'h8000, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, OP_SLT, 16'h1234, 16'h1234, 16'h0000, 1'b0};
    vecs[8] = '{1'b0, 3'b101, 16'h1111, 16'h2222, 16'h0000, 1'b1};
    vecs[9] = '{1'b1, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};

    last_flags = '0;
    rst_n = 0;
    rq0_valid = 0; rq0_op = '0; rq0_a = '0; rq0_b = '0; rs0_ready = 1;
    rq1_valid = 0; rq1_op = '0; rq1_a = '0; rq1_b = '0; rs1_ready = 1;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_rs_valid", {rs1_valid, rs0_valid}, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_op_err", op_err, 0);
    @(negedge clk); rst_n = 1;

    foreach (vecs[i])
      run_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].err);

    // Both ports requesting continuously: grants alternate starting at 0.
    @(negedge clk);
    rq0_valid = 1; rq0_op = OP_AND; rq0_a = 16'hF0F0; rq0_b = 16'h0FF0;
    rq1_valid = 1; rq1_op = OP_OR;  rq1_a = 16'hF0F0; rq1_b = 16'h0FF0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("rr_grant", {rq1_ready, rq0_ready}, (i % 2) ? 2'b10 : 2'b01);
      @(posedge clk); @(posedge clk); #1;
      chk("rr_valid", {rs1_valid, rs0_valid}, (i % 2) ? 2'b10 : 2'b01);
      chk("rr_result", (i % 2) ? rs1_result : rs0_result, (i % 2) ? 16'hFFF0 : 16'h00F0);
      @(posedge clk); #1;
    end
    rq0_valid = 0; rq1_valid = 0;

    // Backpressure on port 0 stalls port 1.
    rs0_ready = 0;
    @(negedge clk);
    rq0_valid = 1; rq0_op = OP_ADD; rq0_a = 16'h0001; rq0_b = 16'h0001;
    @(posedge clk); #1;
    rq0_valid = 0;
    rq1_valid = 1; rq1_op = OP_SUB; rq1_a = 16'h0009; rq1_b = 16'h0004;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rs0_valid", rs0_valid, 1);
      chk("bp_rs0_result", rs0_result, 16'h0002);
      chk("bp_rq1_ready", rq1_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rs0_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_rq1_ready", rq1_ready, 1);
    chk("bp_release_rs0_valid", rs0_valid, 0);
    @(posedge clk); #1;
    rq1_valid = 0;
    @(posedge clk); #1;
    chk("bp_rs1_valid", rs1_valid, 1);
    chk("bp_rs1_result", rs1_result, 16'h0005);
    @(posedge clk); #1;

    // Illegal op interrupted by reset while in EXEC.
    @(negedge clk);
    rq0_valid = 1; rq0_op = 3'b110; rq0_a = 16'h0003; rq0_b = 16'h0003;
    @(posedge clk); #1;
    rq0_valid = 0;
    chk("rst_pre_op_err", op_err, 1);
    chk("rst_pre_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_rs_valid", {rs1_valid, rs0_valid}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_rq_ready", {rq1_ready, rq0_ready}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("rst_no_resp", {rs1_valid, rs0_valid}, 0);
    run_op(1'b0, OP_ADD, 16'h0005, 16'h0003, 16'h0008, 1'b0);

`ifdef ALU_SHARE_FLAGS_EN
    run_op(1'b0, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
    chk("flags_ovf", last_flags, 3'b010);
    run_op(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    chk("flags_cout_zero", last_flags, 3'b101);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
